// File: rtl/pito_dmem_router.sv
// pito_dmem_router
//   Data-side interconnect between two dmem masters (M0 = rv32 core,
//   M1 = external port) and NUM_SLAVES memory-mapped slaves. The two masters
//   are round-robin arbitrated onto one shared slave bus. Each slave is
//   selected by an address-mask decode. The response is routed back one
//   cycle after the grant. Accesses that hit no slave are flagged as decode
//   errors and counted by a saturating counter.
//
//   Handshake: a master raises m_req and holds we/addr/wdata/be stable until
//   m_gnt is high in the same cycle; the transfer happens on the rising edge
//   where req && gnt. Exactly one cycle later m_rvalid pulses for that
//   master, for reads and writes alike. A master may drop m_req before it is
//   granted (cancel) with no side effects. There is no backpressure on the
//   response side.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   m_req/m_we/m_addr/
//   m_wdata/m_be             per-master request fields, M0 in the LSBs
//   m_gnt                    combinational grant
//   m_rvalid/m_rdata/m_err   per-master registered response
//   s_req                    one-hot slave select
//   s_we/s_addr/s_wdata/s_be shared slave bus; s_addr is the in-slave offset
//   s_rdata                  per-slave read data, 1-cycle latency
//   err_clr, err_cnt         decode-error counter clear / value
module pito_dmem_router #(
    parameter int NUM_SLAVES = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE = {32'h8000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK = {32'hFFFF_FFFF, 32'hFFFF_0000},
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA = 32'hDEAD_BEEF,
    parameter int ERRCNT_W = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [1:0]                       m_req,
    input  logic [1:0]                       m_we,
    input  logic [2*ADDR_WIDTH-1:0]          m_addr,
    input  logic [2*DATA_WIDTH-1:0]          m_wdata,
    input  logic [2*(DATA_WIDTH/8)-1:0]      m_be,
    output logic [1:0]                       m_gnt,
    output logic [1:0]                       m_rvalid,
    output logic [2*DATA_WIDTH-1:0]          m_rdata,
    output logic [1:0]                       m_err,
    output logic [NUM_SLAVES-1:0]            s_req,
    output logic                             s_we,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    output logic [DATA_WIDTH/8-1:0]          s_be,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
    input  logic                             err_clr,
    output logic [ERRCNT_W-1:0]              err_cnt
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    // Arbitration state: index of the master granted most recently.
    logic             last_grant;
    logic             gnt_any;
    logic             gnt_idx;

    // Granted master's request fields.
    logic [ADDR_WIDTH-1:0] g_addr;
    logic                  g_we;
    logic [DATA_WIDTH-1:0] g_wdata;
    logic [BE_W-1:0]       g_be;

    // Decode results.
    logic                  hit;
    logic [SEL_W-1:0]      sel;
    logic [ADDR_WIDTH-1:0] sel_mask;
    logic                  dec_err;

    // Response pipeline registers.
    logic             rsp_vld;
    logic             rsp_mst;
    logic [SEL_W-1:0] rsp_slv;
    logic             rsp_err;
    logic [DATA_WIDTH-1:0] slv_data;
    logic [DATA_WIDTH-1:0] rsp_data;

    // A lone requester wins at once; on conflict the master that was not
    // granted last time wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = 1'b0;
        if (m_req[0] && m_req[1]) begin
            gnt_any = 1'b1;
            gnt_idx = ~last_grant;
        end else if (m_req[0]) begin
            gnt_any = 1'b1;
            gnt_idx = 1'b0;
        end else if (m_req[1]) begin
            gnt_any = 1'b1;
            gnt_idx = 1'b1;
        end
    end

    assign m_gnt = gnt_any ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;

    assign g_addr  = gnt_idx ? m_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_addr[ADDR_WIDTH-1:0];
    assign g_we    = gnt_idx ? m_we[1] : m_we[0];
    assign g_wdata = gnt_idx ? m_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : m_wdata[DATA_WIDTH-1:0];
    assign g_be    = gnt_idx ? m_be[2*BE_W-1:BE_W] : m_be[BE_W-1:0];

    // Scanning from the highest index down lets the lowest matching slave
    // overwrite any higher match, so the lowest index wins on overlap.
    always_comb begin
        hit      = 1'b0;
        sel      = '0;
        sel_mask = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((g_addr & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit      = 1'b1;
                sel      = SEL_W'(i);
                sel_mask = SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign dec_err = gnt_any && !hit;

    always_comb begin
        s_req = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            s_req[i] = gnt_any && hit && (sel == SEL_W'(i));
        end
    end

    assign s_we    = g_we;
    assign s_addr  = g_addr & ~sel_mask;
    assign s_wdata = g_wdata;
    assign s_be    = g_be;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_vld    <= 1'b0;
            rsp_mst    <= 1'b0;
            rsp_slv    <= '0;
            rsp_err    <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            rsp_vld <= gnt_any;
            if (gnt_any) begin
                rsp_mst    <= gnt_idx;
                rsp_slv    <= sel;
                rsp_err    <= !hit;
                last_grant <= gnt_idx;
            end
        end
    end

    // Clear has priority over a simultaneous error; the count sticks at
    // all-ones once saturated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (dec_err && (err_cnt != {ERRCNT_W{1'b1}})) begin
            err_cnt <= err_cnt + ERRCNT_W'(1);
        end
    end

    always_comb begin
        slv_data = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (rsp_slv == SEL_W'(i)) begin
                slv_data = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rsp_data = rsp_err ? ERR_RDATA : slv_data;

    // Only the master owning the in-flight response sees non-zero data.
    always_comb begin
        m_rvalid = 2'b00;
        m_err    = 2'b00;
        m_rdata  = '0;
        if (rsp_vld) begin
            if (rsp_mst) begin
                m_rvalid[1]                       = 1'b1;
                m_err[1]                          = rsp_err;
                m_rdata[2*DATA_WIDTH-1:DATA_WIDTH] = rsp_data;
            end else begin
                m_rvalid[0]                = 1'b1;
                m_err[0]                   = rsp_err;
                m_rdata[DATA_WIDTH-1:0]    = rsp_data;
            end
        end
    end

endmodule

// File: tb/tb_pito_dmem_router.sv
// Directed bench for pito_dmem_router with the default address map and a
// 2-bit error counter so saturation is reachable in a few accesses.
module tb_pito_dmem_router;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_req;
  logic [1:0]  m_we;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [7:0]  m_be;
  logic [1:0]  m_gnt;
  logic [1:0]  m_rvalid;
  logic [63:0] m_rdata;
  logic [1:0]  m_err;
  logic [1:0]  s_req;
  logic        s_we;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_be;
  logic [63:0] s_rdata;
  logic        err_clr;
  logic [1:0]  err_cnt;

  int vectors = 0;
  int miscompares = 0;

  pito_dmem_router #(
    .ERRCNT_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .m_req(m_req),
    .m_we(m_we),
    .m_addr(m_addr),
    .m_wdata(m_wdata),
    .m_be(m_be),
    .m_gnt(m_gnt),
    .m_rvalid(m_rvalid),
    .m_rdata(m_rdata),
    .m_err(m_err),
    .s_req(s_req),
    .s_we(s_we),
    .s_addr(s_addr),
    .s_wdata(s_wdata),
    .s_be(s_be),
    .s_rdata(s_rdata),
    .err_clr(err_clr),
    .err_cnt(err_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int m, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    if (m == 0) begin
      m_we[0]        = we;
      m_addr[31:0]   = addr;
      m_wdata[31:0]  = wdata;
      m_be[3:0]      = be;
    end else begin
      m_we[1]        = we;
      m_addr[63:32]  = addr;
      m_wdata[63:32] = wdata;
      m_be[7:4]      = be;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    m_req   = 2'b00;
    m_we    = 2'b00;
    m_addr  = '0;
    m_wdata = '0;
    m_be    = '0;
    err_clr = 1'b0;
    s_rdata = {32'h0000_5678, 32'h0000_1234};

    // reset state
    tick();
    tick();
    chk("rst_rvalid", m_rvalid, 2'b00);
    chk("rst_err", m_err, 2'b00);
    chk("rst_rdata", m_rdata, 64'h0);
    chk("rst_errcnt", err_cnt, 2'd0);
    chk("rst_sreq", s_req, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_rvalid", m_rvalid, 2'b00);

    // M0 read from slave 0
    @(negedge clk);
    set_m(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
    m_req = 2'b01;
    #1;
    chk("rd0_gnt", m_gnt, 2'b01);
    chk("rd0_sreq", s_req, 2'b01);
    chk("rd0_saddr", s_addr, 32'h10);
    chk("rd0_swe", s_we, 1'b0);
    tick();
    chk("rd0_rvalid", m_rvalid, 2'b01);
    chk("rd0_rdata", m_rdata, 64'h0000_0000_0000_1234);
    chk("rd0_err", m_err, 2'b00);

    // M0 write to slave 1 (exact-address slave)
    @(negedge clk);
    set_m(0, 1'b1, 32'h8000_0000, 32'h41, 4'b0001);
    m_req = 2'b01;
    #1;
    chk("wr1_sreq", s_req, 2'b10);
    chk("wr1_swe", s_we, 1'b1);
    chk("wr1_saddr", s_addr, 32'h0);
    chk("wr1_swdata", s_wdata, 32'h41);
    chk("wr1_sbe", s_be, 4'b0001);
    tick();
    chk("wr1_rvalid", m_rvalid, 2'b01);
    chk("wr1_err", m_err, 2'b00);
    chk("wr1_rdata", m_rdata, 64'h0000_0000_0000_5678);

    // M1 decode error
    @(negedge clk);
    m_req = 2'b10;
    set_m(1, 1'b0, 32'h4000_0000, 32'h0, 4'h0);
    #1;
    chk("derr_gnt", m_gnt, 2'b10);
    chk("derr_sreq", s_req, 2'b00);
    tick();
    chk("derr_rvalid", m_rvalid, 2'b10);
    chk("derr_rdata", m_rdata, 64'hDEAD_BEEF_0000_0000);
    chk("derr_err", m_err, 2'b10);
    chk("derr_cnt", err_cnt, 2'd1);

    // Idle cycle: no response
    @(negedge clk);
    m_req = 2'b00;
    tick();
    chk("idle_rvalid", m_rvalid, 2'b00);

    // Conflict held four cycles; last grant was M1, so M0 goes first
    @(negedge clk);
    set_m(0, 1'b0, 32'h0000_0020, 32'h0, 4'h0);
    set_m(1, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
    s_rdata = {32'h0000_AAAA, 32'h0000_5555};
    m_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      chk("conf_gnt", m_gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("conf_sreq", s_req, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("conf_saddr", s_addr, (k % 2 == 0) ? 32'h20 : 32'h0);
      tick();
      chk("conf_rvalid", m_rvalid, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("conf_rdata", m_rdata, (k % 2 == 0) ? 64'h0000_0000_0000_5555 : 64'h0000_AAAA_0000_0000);
    end

    // Clear the counter, then saturate it with five errors
    @(negedge clk);
    m_req = 2'b00;
    err_clr = 1'b1;
    tick();
    chk("clr_cnt", err_cnt, 2'd0);
    @(negedge clk);
    err_clr = 1'b0;
    set_m(1, 1'b0, 32'h4000_0000, 32'h0, 4'h0);
    m_req = 2'b10;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("sat_cnt", err_cnt, (k < 3) ? 2'(k) : 2'd3);
      chk("sat_err", m_err, 2'b10);
    end
    // Sixth error with clear asserted: clear wins
    @(negedge clk);
    err_clr = 1'b1;
    tick();
    chk("clr_win_cnt", err_cnt, 2'd0);
    @(negedge clk);
    err_clr = 1'b0;
    m_req = 2'b00;

    // Reset asserted the cycle after a grant drops the response
    @(negedge clk);
    set_m(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
    m_req = 2'b01;
    tick();
    rst = 1'b1;
    m_req = 2'b00;
    #1;
    chk("rst_flight_rvalid", m_rvalid, 2'b00);
    tick();
    chk("rst_hold_rvalid", m_rvalid, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    set_m(1, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
    m_req = 2'b11;
    #1;
    chk("post_rst2_rvalid", m_rvalid, 2'b00);
    chk("post_rst2_gnt", m_gnt, 2'b01);
    tick();
    chk("post_rst2_resp", m_rvalid, 2'b01);
    chk("post_rst2_rdata", m_rdata, 64'h0000_0000_0000_5555);
    @(negedge clk);
    m_req = 2'b00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
